// File: rtl/dcache_port_arb.sv
// rtl/dcache_port_arb.sv - single data-cache port arbiter between load and store units
//
// Purpose: grants the one D-cache port to either the load or the store unit,
// issues the latched command for the length of the transaction, reports the
// completion back to the owner and aborts a transaction the cache never answers.
//
// Ports:
//   clock, reset                  single clock, synchronous active-high reset
//   ld_req/ld_addr/ld_size        load request (held until ld_grant)
//   st_req/st_addr/st_data/st_size store request (held until st_grant)
//   flush                         squash the in-flight load result
//   Dcache2proc_data/_done        cache read data and completion strobe
//   proc2Dcache_command/addr/data/size  issued command and latched operands
//   ld_grant, st_grant            one-cycle grant pulses (combinational)
//   ld_done/ld_data, st_done      completion pulses (combinational)
//   busy, timeout_err             transaction outstanding / watchdog abort

module dcache_port_arb #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            ld_req,
   input  logic [XLEN-1:0] ld_addr,
   input  logic [1:0]      ld_size,
   input  logic            st_req,
   input  logic [XLEN-1:0] st_addr,
   input  logic [XLEN-1:0] st_data,
   input  logic [1:0]      st_size,
   input  logic            flush,
   input  logic [XLEN-1:0] Dcache2proc_data,
   input  logic            Dcache2proc_done,
   output logic [1:0]      proc2Dcache_command,
   output logic [XLEN-1:0] proc2Dcache_addr,
   output logic [XLEN-1:0] proc2Dcache_data,
   output logic [1:0]      proc2Dcache_size,
   output logic            ld_grant,
   output logic            st_grant,
   output logic            ld_done,
   output logic [XLEN-1:0] ld_data,
   output logic            st_done,
   output logic            busy,
   output logic            timeout_err
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LD_BUSY = 2'd1,
      ST_BUSY = 2'd2
   } state_t;

   localparam logic [1:0] BUS_NONE  = 2'd0;
   localparam logic [1:0] BUS_LOAD  = 2'd1;
   localparam logic [1:0] BUS_STORE = 2'd2;

   // The watchdog fires in the BUSY cycle that would take the counter to
   // TIMEOUT, i.e. the TIMEOUT-th busy cycle without a completion.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t          state_q, state_d;
   logic            last_grant_q, last_grant_d;   // 1 = store was granted last
   logic            squash_q, squash_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] data_q, data_d;
   logic [1:0]      size_q, size_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         squash_q     <= 1'b0;
         cnt_q        <= 8'd0;
         addr_q       <= '0;
         data_q       <= '0;
         size_q       <= 2'd0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         squash_q     <= squash_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         size_q       <= size_d;
      end
   end

   always_comb begin
      state_d             = state_q;
      last_grant_d        = last_grant_q;
      squash_d            = squash_q;
      cnt_d               = cnt_q;
      addr_d              = addr_q;
      data_d              = data_q;
      size_d              = size_q;
      proc2Dcache_command = BUS_NONE;
      proc2Dcache_addr    = addr_q;
      proc2Dcache_data    = data_q;
      proc2Dcache_size    = size_q;
      ld_grant            = 1'b0;
      st_grant            = 1'b0;
      ld_done             = 1'b0;
      ld_data             = '0;
      st_done             = 1'b0;
      busy                = 1'b0;
      timeout_err         = 1'b0;

      if (reset) begin
         // Outputs are forced quiet while reset is high, even though the
         // state register still holds a busy state until the clock edge.
         proc2Dcache_addr = '0;
         proc2Dcache_data = '0;
         proc2Dcache_size = 2'd0;
      end else begin
         case (state_q)
            IDLE: begin
               // Load wins unless a store is also waiting and load went last.
               if (ld_req && (!st_req || last_grant_q)) begin
                  ld_grant     = 1'b1;
                  state_d      = LD_BUSY;
                  last_grant_d = 1'b0;
                  squash_d     = flush;
                  cnt_d        = 8'd0;
                  addr_d       = ld_addr;
                  data_d       = '0;
                  size_d       = ld_size;
               end else if (st_req) begin
                  st_grant     = 1'b1;
                  state_d      = ST_BUSY;
                  last_grant_d = 1'b1;
                  squash_d     = 1'b0;
                  cnt_d        = 8'd0;
                  addr_d       = st_addr;
                  data_d       = st_data;
                  size_d       = st_size;
               end
            end
            LD_BUSY, ST_BUSY: begin
               busy = 1'b1;
               if (Dcache2proc_done) begin
                  // A completion in the watchdog cycle still counts as normal.
                  proc2Dcache_command = (state_q == LD_BUSY) ? BUS_LOAD : BUS_STORE;
                  if (state_q == LD_BUSY) begin
                     if (!(squash_q || flush)) begin
                        ld_done = 1'b1;
                        ld_data = Dcache2proc_data;
                     end
                  end else begin
                     st_done = 1'b1;
                  end
                  state_d  = IDLE;
                  squash_d = 1'b0;
               end else if (cnt_q == TO_LAST) begin
                  timeout_err = 1'b1;
                  cnt_d       = cnt_q + 8'd1;
                  state_d     = IDLE;
                  squash_d    = 1'b0;
               end else begin
                  proc2Dcache_command = (state_q == LD_BUSY) ? BUS_LOAD : BUS_STORE;
                  cnt_d               = cnt_q + 8'd1;
                  if (state_q == LD_BUSY && flush) begin
                     squash_d = 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_port_arb.sv
// tb/tb_dcache_port_arb.sv - directed self-checking bench for dcache_port_arb

module tb_dcache_port_arb;

   localparam int TO = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        ld_req, st_req, flush, Dcache2proc_done;
   logic [31:0] ld_addr, st_addr, st_data, Dcache2proc_data;
   logic [1:0]  ld_size, st_size;
   logic [1:0]  proc2Dcache_command, proc2Dcache_size;
   logic [31:0] proc2Dcache_addr, proc2Dcache_data, ld_data;
   logic        ld_grant, st_grant, ld_done, st_done, busy, timeout_err;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   dcache_port_arb #(.XLEN(32), .TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size),
      .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
      .flush(flush), .Dcache2proc_data(Dcache2proc_data), .Dcache2proc_done(Dcache2proc_done),
      .proc2Dcache_command(proc2Dcache_command), .proc2Dcache_addr(proc2Dcache_addr),
      .proc2Dcache_data(proc2Dcache_data), .proc2Dcache_size(proc2Dcache_size),
      .ld_grant(ld_grant), .st_grant(st_grant), .ld_done(ld_done), .ld_data(ld_data),
      .st_done(st_done), .busy(busy), .timeout_err(timeout_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   // m_kind: 0 no transaction, 1 load outstanding, 2 store outstanding
   // m_age : busy cycles already spent by the outstanding transaction
   int          m_kind = 0;
   int          m_age = 0;
   bit          m_squash = 0;
   bit          m_store_wins = 0;
   logic [31:0] m_addr = 0, m_data = 0;
   logic [1:0]  m_size = 0;
   bit          model_on = 0;

   logic        e_lg, e_sg, e_ld, e_sd, e_busy, e_to;
   logic [1:0]  e_cmd;
   logic [31:0] e_ldata;

   always @(negedge clock) begin
      if (model_on) begin
         e_lg = 0; e_sg = 0; e_ld = 0; e_sd = 0; e_busy = 0; e_to = 0;
         e_cmd = 2'd0; e_ldata = 32'd0;
         if (!reset) begin
            if (m_kind == 0) begin
               if (ld_req && (!st_req || !m_store_wins)) e_lg = 1;
               else if (st_req) e_sg = 1;
            end else begin
               e_busy = 1;
               if (Dcache2proc_done) begin
                  e_cmd = 2'(m_kind);
                  if (m_kind == 1 && !m_squash && !flush) begin
                     e_ld = 1;
                     e_ldata = Dcache2proc_data;
                  end
                  if (m_kind == 2) e_sd = 1;
               end else if (m_age + 1 == TO) begin
                  e_to = 1;
               end else begin
                  e_cmd = 2'(m_kind);
               end
            end
         end

         chk("model ld_grant", 32'(ld_grant), 32'(e_lg));
         chk("model st_grant", 32'(st_grant), 32'(e_sg));
         chk("model ld_done", 32'(ld_done), 32'(e_ld));
         chk("model ld_data", ld_data, e_ldata);
         chk("model st_done", 32'(st_done), 32'(e_sd));
         chk("model busy", 32'(busy), 32'(e_busy));
         chk("model timeout_err", 32'(timeout_err), 32'(e_to));
         chk("model command", 32'(proc2Dcache_command), 32'(e_cmd));
         if (reset) begin
            chk("model rst addr", proc2Dcache_addr, 32'd0);
            chk("model rst data", proc2Dcache_data, 32'd0);
            chk("model rst size", 32'(proc2Dcache_size), 32'd0);
         end else if (e_cmd != 2'd0) begin
            chk("model addr", proc2Dcache_addr, m_addr);
            chk("model data", proc2Dcache_data, m_data);
            chk("model size", 32'(proc2Dcache_size), 32'(m_size));
         end

         // advance the model to the state after the coming clock edge
         if (reset) begin
            m_kind = 0; m_age = 0; m_squash = 0; m_store_wins = 0;
            m_addr = 0; m_data = 0; m_size = 0;
         end else if (m_kind == 0) begin
            if (e_lg) begin
               m_kind = 1; m_age = 0; m_squash = flush; m_store_wins = 1;
               m_addr = ld_addr; m_data = 0; m_size = ld_size;
            end else if (e_sg) begin
               m_kind = 2; m_age = 0; m_squash = 0; m_store_wins = 0;
               m_addr = st_addr; m_data = st_data; m_size = st_size;
            end
         end else if (Dcache2proc_done || e_to) begin
            m_kind = 0; m_squash = 0;
         end else begin
            m_age++;
            if (m_kind == 1 && flush) m_squash = 1;
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clr();
      ld_req = 0; ld_addr = 0; ld_size = 0;
      st_req = 0; st_addr = 0; st_data = 0; st_size = 0;
      flush = 0; Dcache2proc_done = 0; Dcache2proc_data = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      clr();
      reset = 1;
      @(posedge clock); #1;
      model_on = 1;
      tick();
      // reset held with a request and a stray completion
      ld_req = 1; Dcache2proc_done = 1; Dcache2proc_data = 32'hFFFF0000; #3;
      chk("rst no grant", 32'(ld_grant), 0);
      chk("rst no done", 32'(ld_done), 0);
      chk("rst cmd", 32'(proc2Dcache_command), 0);
      tick();

      // both requesters from reset release: load first, store next
      clr(); reset = 0;
      ld_req = 1; ld_addr = 32'h40; ld_size = 2;
      st_req = 1; st_addr = 32'h80; st_data = 32'hA5A5A5A5; st_size = 1; #3;
      chk("tie first ld_grant", 32'(ld_grant), 1);
      chk("tie first st_grant", 32'(st_grant), 0);
      tick();
      ld_req = 0; Dcache2proc_done = 1; Dcache2proc_data = 32'h11; #3;
      chk("tie ld cmd", 32'(proc2Dcache_command), 1);
      chk("tie no st_grant while busy", 32'(st_grant), 0);
      chk("tie ld_done", 32'(ld_done), 1);
      tick();
      Dcache2proc_done = 0; #3;
      chk("tie st_grant after", 32'(st_grant), 1);
      chk("tie idle cmd", 32'(proc2Dcache_command), 0);
      tick();
      st_req = 0; Dcache2proc_done = 1; #3;
      chk("tie st data", proc2Dcache_data, 32'hA5A5A5A5);
      chk("tie st size", 32'(proc2Dcache_size), 1);
      chk("tie st_done", 32'(st_done), 1);
      tick();
      Dcache2proc_done = 0; ld_req = 1; st_req = 1; #3;
      chk("tie2 ld_grant", 32'(ld_grant), 1);
      tick();
      ld_req = 0; st_req = 0; Dcache2proc_done = 1; Dcache2proc_data = 32'h22; #3;
      chk("load data zero", proc2Dcache_data, 0);
      tick();
      clr(); tick();

      // single load, completion on third busy cycle
      ld_req = 1; ld_addr = 32'h100; ld_size = 2; #3;
      chk("ld c0 grant", 32'(ld_grant), 1);
      tick();
      ld_req = 0; #3;
      chk("ld c1 cmd", 32'(proc2Dcache_command), 1);
      chk("ld c1 addr", proc2Dcache_addr, 32'h100);
      chk("ld c1 busy", 32'(busy), 1);
      tick();
      tick();
      Dcache2proc_done = 1; Dcache2proc_data = 32'hDEADBEEF; #3;
      chk("ld c3 done", 32'(ld_done), 1);
      chk("ld c3 data", ld_data, 32'hDEADBEEF);
      tick();
      Dcache2proc_data = 32'h55; #3;
      chk("ld c4 idle busy", 32'(busy), 0);
      chk("idle done ignored", 32'(ld_done), 0);
      chk("idle ld_data zero", ld_data, 0);
      tick();
      clr(); tick();

      // store with flush active during it
      st_req = 1; st_addr = 32'h200; st_data = 32'h12345678; st_size = 0; #3;
      chk("st grant", 32'(st_grant), 1);
      tick();
      st_req = 0; flush = 1; #3;
      chk("st cmd", 32'(proc2Dcache_command), 2);
      chk("st addr", proc2Dcache_addr, 32'h200);
      chk("st data", proc2Dcache_data, 32'h12345678);
      tick();
      Dcache2proc_done = 1; #3;
      chk("st done with flush", 32'(st_done), 1);
      chk("st no ld_done", 32'(ld_done), 0);
      tick();
      clr(); tick();

      // flushed load mid-transaction, then a normal load
      ld_req = 1; ld_addr = 32'h300; ld_size = 2; tick();
      ld_req = 0; flush = 1; tick();
      flush = 0; tick();
      Dcache2proc_done = 1; Dcache2proc_data = 32'hCAFEF00D; #3;
      chk("squash no ld_done", 32'(ld_done), 0);
      chk("squash ld_data zero", ld_data, 0);
      tick();
      Dcache2proc_done = 0; ld_req = 1; ld_addr = 32'h304; #3;
      chk("squash busy drop", 32'(busy), 0);
      chk("post squash grant", 32'(ld_grant), 1);
      tick();
      ld_req = 0; Dcache2proc_done = 1; Dcache2proc_data = 32'h77; #3;
      chk("post squash done", 32'(ld_done), 1);
      chk("post squash data", ld_data, 32'h77);
      tick();
      clr(); tick();

      // flush coincident with the load grant
      ld_req = 1; ld_addr = 32'h308; flush = 1; tick();
      ld_req = 0; flush = 0; Dcache2proc_done = 1; Dcache2proc_data = 32'h99; #3;
      chk("grant flush squash", 32'(ld_done), 0);
      tick();
      clr(); tick();

      // watchdog abort with TIMEOUT=4
      ld_req = 1; ld_addr = 32'h400; tick();
      ld_req = 0; tick();
      tick();
      #3;
      chk("to c3 cmd", 32'(proc2Dcache_command), 1);
      chk("to c3 no err", 32'(timeout_err), 0);
      tick();
      #3;
      chk("to c4 err", 32'(timeout_err), 1);
      chk("to c4 cmd none", 32'(proc2Dcache_command), 0);
      tick();
      Dcache2proc_done = 1; Dcache2proc_data = 32'hBAD; #3;
      chk("to late done ignored", 32'(ld_done), 0);
      chk("to idle", 32'(busy), 0);
      tick();
      clr(); tick();

      // completion in the watchdog cycle wins
      st_req = 1; st_addr = 32'h500; st_data = 32'h5; st_size = 2; tick();
      st_req = 0; tick();
      tick();
      tick();
      Dcache2proc_done = 1; #3;
      chk("edge st_done", 32'(st_done), 1);
      chk("edge no timeout", 32'(timeout_err), 0);
      tick();
      clr(); tick();

      // reset during ST_BUSY
      st_req = 1; st_addr = 32'h600; st_data = 32'h66; tick();
      st_req = 0; tick();
      reset = 1; Dcache2proc_done = 1; #3;
      chk("rst busy no st_done", 32'(st_done), 0);
      chk("rst busy cmd", 32'(proc2Dcache_command), 0);
      chk("rst busy busy", 32'(busy), 0);
      tick();
      reset = 0; Dcache2proc_done = 0; #3;
      chk("after rst cmd", 32'(proc2Dcache_command), 0);
      chk("after rst busy", 32'(busy), 0);
      tick();
      ld_req = 1; st_req = 1; #3;
      chk("after rst tie ld", 32'(ld_grant), 1);
      chk("after rst tie st", 32'(st_grant), 0);
      tick();
      ld_req = 0; st_req = 0; Dcache2proc_done = 1; tick();
      clr(); tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
